// File: rtl/mips_mem_ctrl.sv
// mips_mem_ctrl: Avalon-style memory controller for the multicycle MIPS core.
// Runs one fetch/load/store per request and holds the instruction and memory data registers.
module mips_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_fetch,
    input  logic                req_load,
    input  logic                req_store,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_byteen,
    output logic                busy,
    output logic                done,
    output logic                bus_error,
    output logic [DATA_W-1:0]   instr,
    output logic [DATA_W-1:0]   mdr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, RD_I, RD_D, WR} state_t;
    state_t        state;
    state_t        next_op;
    logic [CW-1:0] wait_cnt;
    logic          any_req;
    logic          misaligned;
    logic          timed_out;
    assign any_req    = req_fetch | req_load | req_store;
    assign misaligned = |req_addr[1:0];
    assign next_op    = req_store ? WR : req_load ? RD_D : RD_I;
    // this wait cycle is the TIMEOUT-th consecutive one
    assign timed_out  = wait_cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus_error      <= 1'b0;
            instr          <= '0;
            mdr            <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (any_req && misaligned) begin
                    bus_error <= 1'b1;
                    done      <= 1'b1;
                end else if (any_req) begin
                    state          <= next_op;
                    busy           <= 1'b1;
                    bus_error      <= 1'b0;
                    wait_cnt       <= '0;
                    avm_address    <= req_addr;
                    avm_writedata  <= req_wdata;
                    avm_byteenable <= (next_op == WR) ? req_byteen : '1;
                    avm_read       <= next_op != WR;
                    avm_write      <= next_op == WR;
                end
            end else if (!avm_waitrequest) begin
                if (state == RD_I) instr <= avm_readdata;
                if (state == RD_D) mdr <= avm_readdata;
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
                if (timed_out) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    bus_error <= 1'b1;
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_mem_ctrl.sv
// tb_mips_mem_ctrl: directed and randomized checks of mips_mem_ctrl against a transaction-level model.
module tb_mips_mem_ctrl;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_fetch = 1'b0, req_load = 1'b0, req_store = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_byteen = '0;
    logic        busy, done, bus_error, avm_read, avm_write;
    logic [31:0] instr, mdr, avm_address, avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    mips_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_fetch(req_fetch), .req_load(req_load), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
        .busy(busy), .done(done), .bus_error(bus_error), .instr(instr), .mdr(mdr),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [31:0] exp_instr = '0, exp_mdr = '0;
    int o_strobes, o_reads, o_writes, o_done, o_ndone;
    logic o_stable, o_busy_ok, o_err;
    logic [31:0] o_addr, o_wd;
    logic [3:0] o_be;

    // Drives one request (r = {store,load,fetch}) and acts as the bus slave for TO+8 cycles.
    // Read data is corrupted while stalled, so only the released cycle carries rd.
    task automatic xfer(input logic [2:0] r, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int waits, input logic [31:0] rd,
                        input logic intrude);
        int wl = waits;
        @(negedge clk);
        {req_store, req_load, req_fetch} = r;
        req_addr = a; req_wdata = wd; req_byteen = be;
        o_strobes = 0; o_reads = 0; o_writes = 0; o_done = -1; o_ndone = 0;
        o_stable = 1'b1; o_busy_ok = 1'b1; o_err = 1'bx;
        o_addr = 'x; o_wd = 'x; o_be = 'x;
        for (int c = 1; c <= TO + 8; c++) begin
            @(negedge clk);
            {req_store, req_load, req_fetch} = 3'b000;
            if (intrude && c == 2) begin
                req_fetch = 1'b1;
                req_addr  = a ^ 32'h40;
            end
            if (avm_read || avm_write) begin
                if (o_strobes == 0) begin
                    o_addr = avm_address; o_wd = avm_writedata; o_be = avm_byteenable;
                end else if (avm_address !== o_addr || avm_writedata !== o_wd || avm_byteenable !== o_be)
                    o_stable = 1'b0;
                o_strobes++;
                o_reads  += int'(avm_read);
                o_writes += int'(avm_write);
                if (busy !== 1'b1) o_busy_ok = 1'b0;
                avm_waitrequest = wl > 0;
                avm_readdata    = (wl > 0) ? ~rd : rd;
                if (wl > 0) wl--;
            end else avm_waitrequest = 1'b0;
            if (done === 1'b1) begin
                o_ndone++;
                if (o_done < 0) begin o_done = c; o_err = bus_error; end
            end
        end
        avm_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, bus_error, avm_read, avm_write, instr, mdr, avm_address, avm_writedata, avm_byteenable} !== '0) begin
            bad++; $display("FAIL reset_outputs got busy=%b done=%b err=%b rd=%b wr=%b instr=%h mdr=%h addr=%h want all 0",
                            busy, done, bus_error, avm_read, avm_write, instr, mdr, avm_address);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fetch();
        xfer(3'b001, 32'h10, 32'h0, 4'h0, 0, 32'h2408002A, 1'b0);
        exp_instr = 32'h2408002A;
        total++; if (o_reads !== 1 || o_writes !== 0) begin bad++; $display("FAIL fetch_strobe got reads=%0d writes=%0d want 1/0", o_reads, o_writes); end
        total++; if (o_addr !== 32'h10) begin bad++; $display("FAIL fetch_addr got=%h want=00000010", o_addr); end
        total++; if (o_done !== 2 || o_ndone !== 1) begin bad++; $display("FAIL fetch_done got cycle=%0d count=%0d want 2/1", o_done, o_ndone); end
        total++; if (instr !== exp_instr || mdr !== exp_mdr) begin bad++; $display("FAIL fetch_regs got instr=%h mdr=%h want %h/%h", instr, mdr, exp_instr, exp_mdr); end
    endtask

    task automatic test_load_wait();
        xfer(3'b010, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0);
        exp_mdr = 32'hDEADBEEF;
        total++; if (o_reads !== 4 || !o_stable || !o_busy_ok) begin bad++; $display("FAIL load_hold got reads=%0d stable=%b busy=%b want 4/1/1", o_reads, o_stable, o_busy_ok); end
        total++; if (o_addr !== 32'h100 || o_be !== 4'hF) begin bad++; $display("FAIL load_addr got addr=%h be=%h want 00000100/f", o_addr, o_be); end
        total++; if (o_done !== 5) begin bad++; $display("FAIL load_done got=%0d want=5", o_done); end
        total++; if (instr !== exp_instr || mdr !== exp_mdr) begin bad++; $display("FAIL load_regs got instr=%h mdr=%h want %h/%h", instr, mdr, exp_instr, exp_mdr); end
    endtask

    task automatic test_store();
        xfer(3'b100, 32'h200, 32'h12345678, 4'b0011, 0, 32'hCAFEF00D, 1'b0);
        total++; if (o_writes !== 1 || o_reads !== 0) begin bad++; $display("FAIL store_strobe got writes=%0d reads=%0d want 1/0", o_writes, o_reads); end
        total++; if (o_addr !== 32'h200 || o_wd !== 32'h12345678 || o_be !== 4'b0011) begin bad++; $display("FAIL store_bus got addr=%h wd=%h be=%b want 00000200/12345678/0011", o_addr, o_wd, o_be); end
        total++; if (o_done !== 2 || o_err !== 1'b0) begin bad++; $display("FAIL store_done got cycle=%0d err=%b want 2/0", o_done, o_err); end
        total++; if (instr !== exp_instr || mdr !== exp_mdr) begin bad++; $display("FAIL store_regs got instr=%h mdr=%h want %h/%h", instr, mdr, exp_instr, exp_mdr); end
    endtask

    task automatic test_priority();
        xfer(3'b111, 32'h300, 32'hA5A55A5A, 4'b1100, 1, 32'h0BADF00D, 1'b0);
        total++; if (o_writes !== 2 || o_reads !== 0) begin bad++; $display("FAIL prio_strobe got writes=%0d reads=%0d want 2/0", o_writes, o_reads); end
        total++; if (o_wd !== 32'hA5A55A5A || o_be !== 4'b1100 || o_done !== 3 || o_ndone !== 1) begin bad++; $display("FAIL prio_bus got wd=%h be=%b done=%0d n=%0d want a5a55a5a/1100/3/1", o_wd, o_be, o_done, o_ndone); end
        total++; if (instr !== exp_instr || mdr !== exp_mdr) begin bad++; $display("FAIL prio_regs got instr=%h mdr=%h want %h/%h", instr, mdr, exp_instr, exp_mdr); end
    endtask

    task automatic test_misaligned();
        xfer(3'b001, 32'h102, 32'h0, 4'h0, 0, 32'h11112222, 1'b0);
        total++; if (o_strobes !== 0 || o_done !== 1 || o_err !== 1'b1) begin bad++; $display("FAIL misalign got strobes=%0d done=%0d err=%b want 0/1/1", o_strobes, o_done, o_err); end
        total++; if (bus_error !== 1'b1 || instr !== exp_instr) begin bad++; $display("FAIL misalign_sticky got err=%b instr=%h want 1/%h", bus_error, instr, exp_instr); end
        xfer(3'b001, 32'h104, 32'h0, 4'h0, 0, 32'h33334444, 1'b0);
        exp_instr = 32'h33334444;
        total++; if (o_err !== 1'b0 || bus_error !== 1'b0 || instr !== exp_instr) begin bad++; $display("FAIL misalign_clear got err=%b instr=%h want 0/%h", bus_error, instr, exp_instr); end
    endtask

    task automatic test_timeout();
        xfer(3'b010, 32'h400, 32'h0, 4'h0, 100, 32'h55556666, 1'b0);
        total++; if (o_reads !== TO || o_done !== TO + 1 || o_ndone !== 1) begin bad++; $display("FAIL timeout got reads=%0d done=%0d n=%0d want %0d/%0d/1", o_reads, o_done, o_ndone, TO, TO + 1); end
        total++; if (o_err !== 1'b1 || bus_error !== 1'b1 || mdr !== exp_mdr || instr !== exp_instr) begin bad++; $display("FAIL timeout_regs got err=%b mdr=%h instr=%h want 1/%h/%h", bus_error, mdr, instr, exp_mdr, exp_instr); end
    endtask

    task automatic test_ignore_busy();
        xfer(3'b010, 32'h500, 32'h0, 4'h0, 3, 32'h77778888, 1'b1);
        exp_mdr = 32'h77778888;
        total++; if (o_reads !== 4 || !o_stable || o_addr !== 32'h500) begin bad++; $display("FAIL ignore_busy got reads=%0d stable=%b addr=%h want 4/1/00000500", o_reads, o_stable, o_addr); end
        total++; if (mdr !== exp_mdr || instr !== exp_instr) begin bad++; $display("FAIL ignore_regs got mdr=%h instr=%h want %h/%h", mdr, instr, exp_mdr, exp_instr); end
    endtask

    task automatic test_random();
        logic [2:0] r;
        logic [31:0] a, wd, rd;
        logic [3:0] be;
        int waits, exp_strobes, exp_done;
        logic mis, exp_err, is_wr;
        for (int i = 0; i < 40; i++) begin
            r = 3'b001 << $urandom_range(0, 2);
            mis = $urandom_range(0, 4) == 0;
            a = ($urandom & 32'hFFFF_FFFC) | (mis ? 32'($urandom_range(1, 3)) : 32'd0);
            wd = $urandom; rd = $urandom; be = 4'($urandom);
            waits = $urandom_range(0, TO + 1);
            is_wr = r[2];
            xfer(r, a, wd, be, waits, rd, 1'b0);
            if (mis) begin exp_strobes = 0; exp_done = 1; exp_err = 1'b1; end
            else if (waits >= TO) begin exp_strobes = TO; exp_done = TO + 1; exp_err = 1'b1; end
            else begin
                exp_strobes = waits + 1; exp_done = waits + 2; exp_err = 1'b0;
                if (r[0]) exp_instr = rd;
                if (r[1]) exp_mdr = rd;
            end
            total++;
            if (o_strobes !== exp_strobes || o_writes !== (is_wr ? exp_strobes : 0) || o_done !== exp_done || o_ndone !== 1 || o_err !== exp_err) begin
                bad++; $display("FAIL rand%0d_timing got strobes=%0d writes=%0d done=%0d n=%0d err=%b want %0d/%0d/%0d/1/%b",
                                i, o_strobes, o_writes, o_done, o_ndone, o_err, exp_strobes, is_wr ? exp_strobes : 0, exp_done, exp_err);
            end
            total++;
            if (exp_strobes > 0 && (o_addr !== a || !o_stable || o_be !== (is_wr ? be : 4'hF) || (is_wr && o_wd !== wd))) begin
                bad++; $display("FAIL rand%0d_bus got addr=%h be=%h wd=%h stable=%b want %h/%h/%h/1", i, o_addr, o_be, o_wd, o_stable, a, is_wr ? be : 4'hF, wd);
            end
            total++;
            if (instr !== exp_instr || mdr !== exp_mdr) begin
                bad++; $display("FAIL rand%0d_regs got instr=%h mdr=%h want %h/%h", i, instr, mdr, exp_instr, exp_mdr);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_fetch = 1'b1; req_addr = 32'h600;
        @(negedge clk);
        req_fetch = 1'b0; avm_waitrequest = 1'b1; avm_readdata = 32'h99990000;
        @(negedge clk);
        total++; if (avm_read !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre got read=%b busy=%b want 1/1", avm_read, busy); end
        reset_n = 1'b0;
        #1;
        total++; if ({avm_read, busy, done, bus_error, instr, mdr} !== '0) begin bad++; $display("FAIL rstmid got read=%b busy=%b done=%b err=%b instr=%h mdr=%h want all 0", avm_read, busy, done, bus_error, instr, mdr); end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_fetch();
        test_load_wait();
        test_store();
        test_priority();
        test_misaligned();
        test_timeout();
        test_ignore_busy();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_mem_ctrl.md
Name: mips_mem_ctrl

Overview:
- Memory-bus controller and instruction/data holding registers for the multicycle MIPS core.
- Sits between the control decoder and an Avalon-style memory port.
- Executes one fetch, load or store transaction per request and holds the bus until `waitrequest` clears.
- Latches the fetched word into the instruction register, which feeds the decoder's `Instr` input, and latches loaded data into the memory data register (MDR).
- Reports completion and bus timeouts back to the control FSM.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width; byte enables are DATA_W/8 bits.
- TIMEOUT, 255, maximum consecutive `waitrequest` cycles before the transaction is aborted.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_fetch  input  1  request instruction read at req_addr.
- req_load  input  1  request data read at req_addr.
- req_store  input  1  request data write at req_addr.
- req_addr  input  ADDR_W  byte address, must be word-aligned.
- req_wdata  input  DATA_W  store data.
- req_byteen  input  DATA_W/8  store byte enables; ignored for reads.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- bus_error  output  1  sticky error flag: timeout or misaligned address.
- instr  output  DATA_W  instruction register, drives decoder `Instr`.
- mdr  output  DATA_W  memory data register.
- avm_address  output  ADDR_W  bus address.
- avm_read  output  1  bus read strobe.
- avm_write  output  1  bus write strobe.
- avm_writedata  output  DATA_W  bus write data.
- avm_byteenable  output  DATA_W/8  bus byte enables.
- avm_readdata  input  DATA_W  bus read data.
- avm_waitrequest  input  1  bus stall.

Behaviour:
- Clock and reset: one clock domain, `clk`. Reset is asynchronous and active-low on `reset_n`.
- Reset values: every output and register is 0, state = IDLE, timeout counter = 0. If `reset_n` is asserted mid-transaction, the bus strobes drop immediately and the transaction is abandoned.
- States: IDLE, RD_I, RD_D, WR.
- Request acceptance:
  - Requests are sampled only in IDLE. Requests arriving in any other state are ignored; requesters wait for `done`.
  - Simultaneous requests use priority store > load > fetch. Only one is accepted.
- Misaligned address: if `req_addr[1:0]` != 0 on an accepted request, there is no bus access. `bus_error` is set, `done` pulses the next cycle and the state stays IDLE.
- Accepting a request (edge E0):
  - Clear `bus_error`.
  - Register `avm_address`, `avm_writedata` and `avm_byteenable`.
  - Assert `avm_read` (RD_I/RD_D) or `avm_write` (WR).
  - `avm_byteenable` is 4'b1111 for reads and `req_byteen` for stores.
- Bus outputs are registered and held constant while `avm_waitrequest` = 1.
- Completion, on the edge where a strobe is high and `avm_waitrequest` = 0:
  - RD_I captures `avm_readdata` into `instr`.
  - RD_D captures `avm_readdata` into `mdr`.
  - WR captures nothing.
  - Strobes deassert, state returns to IDLE and `done` = 1 for exactly the next cycle.
- Latency: with zero wait states, `done` is high in the second cycle after E0. Each wait cycle adds one.
- `instr` and `mdr` hold their values between transactions. A load never changes `instr`; a fetch never changes `mdr`.
- `busy` = (state != IDLE), registered with the state.
- Timeout:
  - The counter increments on each cycle in a bus state with `avm_waitrequest` = 1, and resets to 0 on acceptance.
  - When it reaches TIMEOUT, strobes deassert, state goes to IDLE, `bus_error` is set, `done` pulses, and `instr`/`mdr` are unchanged.
- `bus_error` stays set until the next accepted request or reset.
- A new request may be accepted in the same cycle `done` is high, since the state is already IDLE.

Test Plan:
- Reset, then fetch at 0x00000010 with readdata 0x2408002A and zero wait → `avm_read`=1 with address 0x10 for 1 cycle; `instr`=0x2408002A; `done` pulses 2 cycles after the request; `mdr`=0.
- Load at 0x100 with `waitrequest` high 3 cycles, readdata 0xDEADBEEF → address and strobe stable for 4 cycles; `mdr`=0xDEADBEEF; `instr` unchanged; `done` 5 cycles after the request.
- Store at 0x200, wdata 0x12345678, byteen 4'b0011 → `avm_write`=1, `avm_writedata`=0x12345678, `avm_byteenable`=4'b0011; `done` pulses; `instr`/`mdr` unchanged.
- Fetch, load and store asserted together → only the store is issued; the other requests are ignored until `busy` drops.
- Fetch at 0x102 → no bus strobe, `bus_error`=1, `done` pulse; then an aligned fetch clears `bus_error`. Separately, hold `waitrequest` high for TIMEOUT=4 → abort after 4 wait cycles with `bus_error`=1.
- Assert `reset_n`=0 during a 2-wait read → `avm_read`, `busy` and `done` go to 0 immediately; `instr`=0.
